// File: rtl/ls_queue_pkg.sv
// Shared types for the load/store queue: queue entry, ls_unit packet and the
// conversion between them.
package ls_queue_pkg;

  localparam int XLEN        = 32;
  localparam int ROB_TAG_LEN = 5;
  localparam int LSQ_DEPTH   = 8;

  typedef struct packed {
    logic [ROB_TAG_LEN-1:0] tag;
    logic                   read_write;  // 1 = load
    logic [2:0]             func3;
    logic [XLEN-1:0]        imm;
    logic [ROB_TAG_LEN-1:0] src1_tag;
    logic [XLEN-1:0]        src1_value;
    logic                   src1_ready;
    logic [ROB_TAG_LEN-1:0] src2_tag;
    logic [XLEN-1:0]        src2_value;
    logic                   src2_ready;
  } lsq_entry_t;

  typedef struct packed {
    logic [ROB_TAG_LEN-1:0] tag;
    logic                   read_write;
    logic [2:0]             func3;
    logic [XLEN-1:0]        imm;
    logic [XLEN-1:0]        value_src1;
    logic [XLEN-1:0]        value_src2;
  } ls_unit_pack_t;

  function automatic ls_unit_pack_t to_ls_unit_pack(input lsq_entry_t e);
    ls_unit_pack_t p;
    p.tag        = e.tag;
    p.read_write = e.read_write;
    p.func3      = e.func3;
    p.imm        = e.imm;
    p.value_src1 = e.src1_value;
    p.value_src2 = e.src2_value;
    return p;
  endfunction

endpackage

// File: rtl/ls_queue_if.sv
// Dispatch / CDB / ls_unit facing signals of the load/store queue.
interface ls_queue_if import ls_queue_pkg::*; #(parameter int DEPTH = LSQ_DEPTH);

  logic                     flush;
  logic                     enq_valid;
  lsq_entry_t               enq_pack;
  logic                     enq_ready;
  logic                     cdb_valid;
  logic [ROB_TAG_LEN-1:0]   cdb_tag;
  logic [XLEN-1:0]          cdb_value;
  logic [ROB_TAG_LEN-1:0]   rob_head_tag;
  logic                     fu_reg_empty;
  logic                     issue_en;
  ls_unit_pack_t            issue_pack;
  logic                     done;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  flush, enq_valid, enq_pack, cdb_valid, cdb_tag, cdb_value,
           rob_head_tag, fu_reg_empty, done,
    output enq_ready, issue_en, issue_pack, count
  );

  modport master (
    output flush, enq_valid, enq_pack, cdb_valid, cdb_tag, cdb_value,
           rob_head_tag, fu_reg_empty, done,
    input  enq_ready, issue_en, issue_pack, count
  );

endinterface

// File: rtl/lsq_entry.sv
// One queue slot: stored instruction, valid bit, and CDB operand capture
// (including a broadcast that lands in the same cycle as the write).
module lsq_entry import ls_queue_pkg::*; (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   wr_en,
  input  lsq_entry_t             wr_pack,
  input  logic                   clr,
  input  logic                   cdb_valid,
  input  logic [ROB_TAG_LEN-1:0] cdb_tag,
  input  logic [XLEN-1:0]        cdb_value,
  output logic                   valid,
  output lsq_entry_t             entry
);

  logic       valid_reg, valid_next;
  lsq_entry_t entry_reg, entry_next;

  always_comb begin
    valid_next = valid_reg;
    entry_next = entry_reg;
    if (flush) begin
      valid_next = 1'b0;
    end else begin
      if (clr)
        valid_next = 1'b0;
      if (wr_en) begin
        valid_next = 1'b1;
        entry_next = wr_pack;
      end
      // Wakeup sees the freshly written operands as well as held ones.
      if (cdb_valid && (wr_en || valid_reg)) begin
        if (!entry_next.src1_ready && entry_next.src1_tag == cdb_tag) begin
          entry_next.src1_value = cdb_value;
          entry_next.src1_ready = 1'b1;
        end
        if (!entry_next.src2_ready && entry_next.src2_tag == cdb_tag) begin
          entry_next.src2_value = cdb_value;
          entry_next.src2_ready = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      entry_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      entry_reg <= entry_next;
    end
  end

  assign valid = valid_reg;
  assign entry = entry_reg;

endmodule

// File: rtl/ls_queue.sv
// In-order load/store queue: circular buffer of lsq_entry slots presenting the
// oldest instruction to ls_unit once its operands (and, for stores, commit) allow.
module ls_queue import ls_queue_pkg::*; #(
  parameter int DEPTH = LSQ_DEPTH
) (
  input logic        clk,
  input logic        reset,
  ls_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic       valid_q [DEPTH];
  lsq_entry_t entry_q [DEPTH];

  logic       enq_fire, deq_fire;
  logic       head_valid, load_ok, store_ok;
  lsq_entry_t head_entry;

  // No bypass: a full queue refuses even when the head retires this cycle.
  assign bus.enq_ready = (count_reg < CNT_W'(DEPTH));
  assign enq_fire      = bus.enq_valid && bus.enq_ready;
  assign deq_fire      = bus.issue_en && bus.done;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      lsq_entry u_entry (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .wr_en     (enq_fire && (tail_reg == PTR_W'(gi))),
        .wr_pack   (bus.enq_pack),
        .clr       (deq_fire && (head_reg == PTR_W'(gi))),
        .cdb_valid (bus.cdb_valid),
        .cdb_tag   (bus.cdb_tag),
        .cdb_value (bus.cdb_value),
        .valid     (valid_q[gi]),
        .entry     (entry_q[gi])
      );
    end
  endgenerate

  assign head_entry = entry_q[head_reg];
  assign head_valid = valid_q[head_reg];
  assign load_ok    = head_valid && head_entry.read_write && head_entry.src1_ready;
  assign store_ok   = head_valid && !head_entry.read_write && head_entry.src1_ready &&
                      head_entry.src2_ready && (head_entry.tag == bus.rob_head_tag);

  assign bus.issue_en   = (load_ok || store_ok) && bus.fu_reg_empty;
  assign bus.issue_pack = to_ls_unit_pack(head_entry);
  assign bus.count      = count_reg;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (bus.flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (enq_fire)
        tail_next = tail_reg + 1'b1;
      if (deq_fire)
        head_next = head_reg + 1'b1;
      count_next = count_reg + CNT_W'(enq_fire) - CNT_W'(deq_fire);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: doc/ls_queue.md
# ls_queue

In-order load/store queue sitting directly upstream of `ls_unit`. It buffers memory instructions from dispatch and captures missing operands from the CDB. It presents the oldest instruction to `ls_unit` once that instruction is eligible, and retires it when `ls_unit` signals `done`. Loads issue as soon as their base operand is ready; stores additionally wait until they are the ROB head, so no speculative write reaches memory.

## Interface
- `DEPTH`, 8: number of entries; power of two, ≥2.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears the queue.
- `flush` input 1: synchronous squash of all entries (branch mispredict).
- `enq_valid` input 1: dispatch presents an instruction this cycle.
- `enq_pack` input LSQ_ENTRY: instruction fields:
  - tag, read_write (1 = load), func3, imm;
  - src1/src2 tag, value and ready bit.
- `enq_ready` output 1: queue can accept; equals `count < DEPTH`.
- `cdb_valid` input 1: CDB broadcast valid.
- `cdb_tag` input `ROB_TAG_LEN`: broadcast producer tag.
- `cdb_value` input `XLEN`: broadcast result.
- `rob_head_tag` input `ROB_TAG_LEN`: tag of the oldest uncommitted instruction.
- `fu_reg_empty` input 1: downstream FU output register free; forwarded to `ls_unit`.
- `issue_en` output 1: drives `ls_unit.en`.
- `issue_pack` output LS_UNIT_PACK: head entry formatted for `ls_unit.insn_in`.
- `done` input 1: from `ls_unit`; head instruction completed this cycle.
- `count` output `$clog2(DEPTH)+1`: occupied entries.

## Operation
- Circular buffer with `head`/`tail` pointers of `$clog2(DEPTH)` bits, wrapping modulo DEPTH. Each entry has a valid bit.
- Enqueue: when `enq_valid && enq_ready`, write `enq_pack` at `tail` and increment `tail`.
- Enqueue with same-cycle CDB hit: if `cdb_valid` and `cdb_tag` matches an enq source tag whose ready bit is 0, store `cdb_value` with ready = 1.
- Wakeup: every valid entry with a non-ready source whose tag equals `cdb_tag` (while `cdb_valid`) latches `cdb_value` and sets ready.
- Head eligibility:
  - Load: head valid and src1 ready.
  - Store: head valid, src1 and src2 ready, and head tag == `rob_head_tag`.
- Issue: `issue_en` = head eligible && `fu_reg_empty`.
- `issue_pack` is driven from the head entry regardless of eligibility; it must be stable while `issue_en` is held.
- Dequeue: on `issue_en && done`, clear the head valid bit and increment `head`. If `done` is low, the head stays and is re-presented (memory miss: retry every cycle).
- Simultaneous enqueue and dequeue: both occur and `count` is unchanged. When full, `enq_ready` stays 0 that cycle even if a dequeue happens (no bypass).
- Priority: `reset` > `flush` > enqueue/dequeue/wakeup. Flush clears all valid bits and sets head = tail = count = 0; an enqueue in the flush cycle is dropped.
- Address arithmetic (src1 + imm) is not computed here; `ls_unit` owns it.

## Timing
- Reset values:
  - `head`, `tail`, `count`, all valid and ready bits: 0.
  - `enq_ready`: 1.
  - `issue_en`: 0.
  - `issue_pack`: all zeros.
- Enqueue-to-issue latency: 1 cycle minimum. An instruction enqueued at edge t can assert `issue_en` during cycle t+1.
- Wakeup latency: a CDB broadcast in cycle t makes the operand ready at edge t+1. Issue is possible in cycle t+1.
- `issue_en` and `issue_pack` are combinational from registered state plus `fu_reg_empty` and `rob_head_tag`. There is no combinational path from `done` to `issue_en`.
- Throughput: one dequeue per cycle when `ls_unit` hits every cycle.
- Reset mid-issue: outputs go to their reset values immediately (asynchronous reset); the pending access is abandoned.

## Structure
- `ls_queue.svh` holds:
  - the `LSQ_ENTRY` typedef;
  - an `LSQ_DEPTH` default;
  - a helper to convert LSQ_ENTRY to LS_UNIT_PACK.
- `XLEN`, `ROB_TAG_LEN` and LS_UNIT_PACK come from `sys_defs.svh`.
- One natural sub-module, `lsq_entry`, holds one slot's storage and its CDB tag-compare/wakeup logic. It is instantiated DEPTH times with a generate loop.

## Test plan
- Reset, then enqueue a load with src1 ready (value 0x100, imm 4) → `issue_en` = 1 the next cycle, with `issue_pack` value_src1 = 0x100 and imm = 4. `done` = 1 → `count` returns to 0.
- Enqueue a load with src1 not ready (tag 5); in a later cycle broadcast CDB tag 5, value 0x2000 → `issue_en` rises exactly one cycle after the broadcast, carrying value 0x2000.
- Enqueue a store with both operands ready and tag 7, with `rob_head_tag` = 3 → `issue_en` stays 0. Set `rob_head_tag` = 7 → issue occurs the same cycle.
- Fill 8 entries → `enq_ready` = 0 and `count` = 8. Drive enqueue plus dequeue in one cycle → enqueue rejected, `count` = 7. Continue to wrap the pointers → FIFO order is preserved across the wrap.
- Hold `done` = 0 for 3 cycles while issuing (miss) → the same `issue_pack` is presented each cycle. Then `done` = 1 → advance to the next entry.
- Assert `flush` together with `enq_valid` while holding 4 entries → the next cycle `count` = 0 and `issue_en` = 0. A separate test asserts async `reset` mid-cycle → `issue_en` drops immediately.
